// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: state encoding, frame width and
// the default oversample ratio.
// Build option: UART_RX_PARITY_EN adds an even-parity bit between the data
// bits and the stop bit.
package uart_pkg;

    localparam int UART_DATA_BITS     = 8;
    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } rx_state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity: XOR across data and parity bit must be 0.
    function automatic logic parity_mismatch(input logic [UART_DATA_BITS-1:0] data,
                                             input logic                      par_bit);
        return ^{data, par_bit};
    endfunction
`endif

endpackage

// File: rtl/uart_rx_sync.sv
// Front end for the UART receiver: brings the asynchronous rx line into the
// system_clk domain, flags its falling edges, and turns the oversample clock
// level into a single-cycle tick per rising edge.
module uart_rx_sync (
    input  logic i_system_clk,
    input  logic i_reset,
    input  logic i_baud_rate_clock,
    input  logic i_rx,
    output logic o_rx_sync,
    output logic o_rx_fall,
    output logic o_tick
);

    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;
    logic r_baud_q;
    logic r_baud_prev;
    logic r_tick;

    // Two-flop synchronizer plus one history flop for edge detect; idle-high reset.
    always_ff @(posedge i_system_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Register the baud level, then pulse tick one cycle after the copy rises.
    always_ff @(posedge i_system_clk or posedge i_reset) begin
        if (i_reset) begin
            r_baud_q    <= 1'b0;
            r_baud_prev <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_baud_q    <= i_baud_rate_clock;
            r_baud_prev <= r_baud_q;
            r_tick      <= r_baud_q & ~r_baud_prev;
        end
    end

    assign o_rx_sync = r_rx_sync;
    assign o_rx_fall = r_rx_prev & ~r_rx_sync;
    assign o_tick    = r_tick;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, 1 stop bit, OVERSAMPLE ticks per bit.
// Build option: UART_RX_PARITY_EN inserts an even-parity bit before the stop
// bit; without it rx_parity_err is tied low and the PARITY state is absent.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                      system_clk,
    input  logic                      reset,
    input  logic                      baud_rate_clock,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      rx_frame_err,
    output logic                      rx_parity_err,
    output logic                      rx_busy
);

    localparam int                 CW       = $clog2(OVERSAMPLE);
    // START checks the line on the OVERSAMPLE/2-th tick after the falling edge.
    localparam logic [CW-1:0]      CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    // After START clears the counter, reaching this value is one bit later (mid-bit).
    localparam logic [CW-1:0]      CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [2:0]         BIT_LAST = 3'(UART_DATA_BITS - 1);

    logic                      w_rx_sync;
    logic                      w_rx_fall;
    logic                      w_tick;
    logic                      w_par_err;
    logic                      w_sample;

    rx_state_t                 r_state;
    logic [CW-1:0]             r_cnt;
    logic [2:0]                r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_rx_data;
    logic                      r_rx_valid;
    logic                      r_rx_frame_err;
    logic                      r_busy;
`ifdef UART_RX_PARITY_EN
    logic                      r_par_bit;
    logic                      r_rx_parity_err;
`endif

    uart_rx_sync u_sync (
        .i_system_clk      (system_clk),
        .i_reset           (reset),
        .i_baud_rate_clock (baud_rate_clock),
        .i_rx              (rx),
        .o_rx_sync         (w_rx_sync),
        .o_rx_fall         (w_rx_fall),
        .o_tick            (w_tick)
    );

    assign w_sample = w_tick && (r_cnt == CNT_LAST);

`ifdef UART_RX_PARITY_EN
    assign w_par_err = parity_mismatch(r_shift, r_par_bit);
`else
    assign w_par_err = 1'b0;
`endif

    // Receive FSM: frame sequencing, bit sampling and registered result pulses.
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_bit_idx      <= '0;
            r_shift        <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rx_frame_err <= 1'b0;
            r_busy         <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit       <= 1'b0;
            r_rx_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_valid     <= 1'b0;
            r_rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_rx_parity_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    // Edge-triggered, so a line stuck low never restarts a frame.
                    if (w_rx_fall) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                START: begin
                    if (w_tick) begin
                        if (r_cnt == CNT_HALF) begin
                            r_cnt <= '0;
                            if (!w_rx_sync) begin
                                r_state   <= DATA;
                                r_bit_idx <= '0;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end

                DATA: begin
                    if (w_tick) begin
                        r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
                    end
                    if (w_sample) begin
                        r_shift   <= {w_rx_sync, r_shift[UART_DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
                    end
                    if (w_sample) begin
                        r_par_bit <= w_rx_sync;
                        r_state   <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (w_tick) begin
                        r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
                    end
                    if (w_sample) begin
                        r_state        <= IDLE;
                        r_busy         <= 1'b0;
                        r_rx_valid     <= w_rx_sync & ~w_par_err;
                        r_rx_frame_err <= ~w_rx_sync;
`ifdef UART_RX_PARITY_EN
                        r_rx_parity_err <= w_par_err;
`endif
                        if (w_rx_sync && !w_par_err) begin
                            r_rx_data <= r_shift;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_frame_err = r_rx_frame_err;
    assign rx_busy      = r_busy;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = r_rx_parity_err;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule
